gf180mcu_fd_sc_mcu9t5v0__subs_serial: RTL and testbench
=======================================================

GF180MCU_FD_SC_MCU9T5V0__SUBS_SERIAL -- requirements
Module: gf180mcu_fd_sc_mcu9t5v0__subs_serial

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving bits per word; legal range 1..32.
REQ-002 SHALL have port CLK, input, 1 bit: the only clock; all state updates on its rising edge.
REQ-003 SHALL have port RN, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have port EN, input, 1 bit: the A/B/START/BI bits are valid this cycle.
REQ-005 SHALL have port START, input, 1 bit: the current bit is the LSB of a new word; qualified by EN.
REQ-006 SHALL have port A, input, 1 bit: minuend bit, LSB first.
REQ-007 SHALL have port B, input, 1 bit: subtrahend bit, LSB first.
REQ-008 SHALL have port BI, input, 1 bit: initial borrow-in, sampled only on EN&START.
REQ-009 SHALL have port D, output, 1 bit: registered difference bit.
REQ-010 SHALL have port DV, output, 1 bit: D is valid; 1-cycle pulse per accepted bit.
REQ-011 SHALL have port BO, output, 1 bit: final borrow-out of the last completed word.
REQ-012 SHALL have port DONE, output, 1 bit: 1-cycle pulse coincident with DV of the word's MSB.
REQ-013 SHALL have port BUSY, output, 1 bit: high while in RUN.
REQ-014 SHALL have ports VDD and VSS, inout, 1 bit each: supply pins, with no functional effect.

Function
REQ-015 SHALL have two states, IDLE and RUN, plus a borrow register BR, a bit counter CNT of ceil(log2(WIDTH+1)) bits, and registered outputs.
REQ-016 SHALL accept a bit in a cycle when EN=1 and either START=1 (any state) or state=RUN.
- EN=1, START=0 in IDLE: ignored; no DV, no state change.
REQ-017 SHALL, for each accepted bit, use borrow source bin = BI when START=1, else BR.
REQ-018 SHALL compute the difference bit as d = A ^ B ^ bin.
REQ-019 SHALL compute the next borrow as bn = (~A & B) | (~(A ^ B) & bin).
REQ-020 SHALL, on each accepted bit at the next edge: D <= d, DV <= 1, BR <= bn.
- Latency: exactly 1 cycle from input bit to D/DV.
REQ-021 SHALL, in a cycle with no accepted bit, drive DV=0 and DONE=0 at the next edge; D, BR and CNT hold.
- EN low mid-word is a stall of any length, with no loss of state.
REQ-022 SHALL, on an accepted START bit, set CNT to 1 (counting this bit).
- If WIDTH>1: enter RUN.
- If WIDTH=1: the word completes immediately (REQ-024).
REQ-023 SHALL, on an accepted non-START bit in RUN, increment CNT.
REQ-024 SHALL treat the WIDTH-th accepted bit as the MSB; at the next edge: DONE <= 1, BO <= bn, state <= IDLE, CNT <= 0.
REQ-025 SHALL, on EN&START while in RUN, abort the current word and start the new one.
- No DONE is issued for the aborted word.
- BO keeps its previous value.
- The START bit is processed per REQ-017..REQ-022.
REQ-026 SHALL hold BO from one DONE until the next DONE; BO SHALL never change otherwise.
REQ-027 SHALL allow back-to-back words: the cycle after the MSB is accepted may carry EN&START, with no bubble required.
REQ-028 SHALL drive BUSY=1 exactly when state=RUN (registered).

Reset
REQ-029 SHALL, while RN=0 and independent of CLK, force the following:
- state=IDLE
- CNT=0, BR=0
- D=0, DV=0, DONE=0, BO=0, BUSY=0
REQ-030 SHALL, on RN low mid-word, discard the partial word with no DONE; after RN rises, a new word requires EN&START.
REQ-031 SHALL act on the first rising CLK edge after RN deasserts, accepting a bit on that edge if offered.

Verification
REQ-032 Bench SHALL drive WIDTH=8, BI=0, A=0x05, B=0x03 LSB first with EN continuous.
- D stream 0x02 (LSB first), 8 DV pulses.
- DONE on the 8th DV, BO=0.
REQ-033 Bench SHALL drive WIDTH=8, BI=0, A=0x03, B=0x05.
- D stream 0xFE, BO=1.
- Then immediately drive A=0x10, B=0x01 back-to-back: D stream 0x0F, BO=0.
REQ-034 Bench SHALL drive WIDTH=8, BI=1, A=0x00, B=0x00.
- D stream 0xFF, BO=1.
REQ-035 Bench SHALL drive A=0xA5, B=0x5A, BI=0 with EN low for 3 cycles after bit 3 and bit 6.
- D stream 0x4B, BO=0.
- No DV during the stalls; BUSY stays high through them.
REQ-036 Bench SHALL issue EN&START after 4 bits of word A=0xFF, B=0x00.
- Then deliver A=0x00, B=0x01: D stream 0xFF, BO=1, exactly one DONE.
- Separately, pull RN low after bit 5: all outputs go to 0 immediately and no DONE occurs.
REQ-037 Bench SHALL run WIDTH=1 with A=0, B=1, BI=0.
- D=1, DV=1, DONE=1 in the same cycle, BO=1, BUSY never asserted.

Source files
------------

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__subs_serial.sv
// Bit-serial subtractor, LSB first: D = A - B - BI one bit per accepted cycle,
// with a DONE pulse and the final borrow-out on BO when the word's MSB has been processed.
module gf180mcu_fd_sc_mcu9t5v0__subs_serial #(
  parameter int unsigned WIDTH = 8
) (
  input  logic CLK,
  input  logic RN,
  input  logic EN,
  input  logic START,
  input  logic A,
  input  logic B,
  input  logic BI,
  output logic D,
  output logic DV,
  output logic BO,
  output logic DONE,
  output logic BUSY,
  inout  wire  VDD,
  inout  wire  VSS
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_q;
  state_t           state_n;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_n;
  logic [CNT_W-1:0] cnt_inc;
  logic             br_q;
  logic             br_n;
  logic             d_n;
  logic             dv_n;
  logic             done_n;
  logic             bo_n;
  logic             busy_n;
  logic             accept;
  logic             bin;
  logic             diff_bit;
  logic             borrow_next;
  logic             unused_supply;

  // Supply pins carry no function.
  assign unused_supply = VDD ^ VSS;

  // Next-state, borrow chain and output values.
  always_comb begin
    state_n     = state_q;
    cnt_n       = cnt_q;
    br_n        = br_q;
    d_n         = D;
    dv_n        = 1'b0;
    done_n      = 1'b0;
    bo_n        = BO;
    accept      = EN & (START | (state_q == RUN));
    bin         = START ? BI : br_q;
    diff_bit    = A ^ B ^ bin;
    borrow_next = (~A & B) | (~(A ^ B) & bin);
    // START restarts the count at this bit, which also aborts any word in flight.
    cnt_inc     = START ? CNT_W'(1) : cnt_q + CNT_W'(1);

    if (accept) begin
      d_n  = diff_bit;
      dv_n = 1'b1;
      br_n = borrow_next;
      if (cnt_inc == CNT_W'(WIDTH)) begin
        done_n  = 1'b1;
        bo_n    = borrow_next;
        state_n = IDLE;
        cnt_n   = '0;
      end else begin
        state_n = RUN;
        cnt_n   = cnt_inc;
      end
    end

    busy_n = (state_n == RUN);
  end

  // State and registered outputs.
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      D       <= 1'b0;
      DV      <= 1'b0;
      DONE    <= 1'b0;
      BO      <= 1'b0;
      BUSY    <= 1'b0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      br_q    <= br_n;
      D       <= d_n;
      DV      <= dv_n;
      DONE    <= done_n;
      BO      <= bo_n;
      BUSY    <= busy_n;
    end
  end

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__subs_serial.sv
// Self-checking bench: directed word table, abort/reset/width-1 corner cases,
// and random traffic against an arithmetic reference model.
module tb_gf180mcu_fd_sc_mcu9t5v0__subs_serial;

  localparam int unsigned W = 8;

  logic CLK = 1'b0;
  logic RN, EN, START, A, B, BI;
  logic D, DV, BO, DONE, BUSY;
  logic en1, start1, a1, b1, bi1;
  logic d1, dv1, bo1, done1, busy1;
  wire  vdd;
  wire  vss;
  assign vdd = 1'b1;
  assign vss = 1'b0;

  always #5 CLK = ~CLK;

  gf180mcu_fd_sc_mcu9t5v0__subs_serial #(.WIDTH(W)) dut (
    .CLK(CLK), .RN(RN), .EN(EN), .START(START), .A(A), .B(B), .BI(BI),
    .D(D), .DV(DV), .BO(BO), .DONE(DONE), .BUSY(BUSY), .VDD(vdd), .VSS(vss)
  );

  gf180mcu_fd_sc_mcu9t5v0__subs_serial #(.WIDTH(1)) dut1 (
    .CLK(CLK), .RN(RN), .EN(en1), .START(start1), .A(a1), .B(b1), .BI(bi1),
    .D(d1), .DV(dv1), .BO(bo1), .DONE(done1), .BUSY(busy1), .VDD(vdd), .VSS(vss)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       bi;
    logic [7:0] stall;
    logic [7:0] exp_d;
    logic       exp_bo;
  } vec_t;

  vec_t tbl[5];

  int vectors = 0;
  int miscompares = 0;

  // Reference model: the word so far as integers, difference by plain subtraction.
  bit     m_run;
  int     m_cnt;
  longint m_a, m_b;
  int     m_bi;
  logic   e_d, e_dv, e_done, e_bo;

  logic [31:0] got_d;
  int          got_dv;
  int          got_done;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_cnt = 0; m_a = 0; m_b = 0; m_bi = 0;
    e_d = 0; e_dv = 0; e_done = 0; e_bo = 0;
  endtask

  // One clock of the 8-bit DUT: drive, predict, sample after the edge, compare.
  task automatic step(input logic en, input logic st, input logic a, input logic b, input logic bi);
    logic   acc;
    longint diff;
    EN = en; START = st; A = a; B = b; BI = bi;
    acc    = en && (st || m_run);
    e_dv   = 0;
    e_done = 0;
    if (acc) begin
      if (st) begin
        m_cnt = 0; m_a = 0; m_b = 0; m_bi = int'(bi);
      end
      m_a  = m_a | (longint'(a) << m_cnt);
      m_b  = m_b | (longint'(b) << m_cnt);
      diff = m_a - m_b - longint'(m_bi);
      e_d  = diff[m_cnt];
      m_cnt++;
      e_dv = 1;
      if (m_cnt == int'(W)) begin
        e_done = 1;
        e_bo   = (diff < 0);
        m_run  = 0;
        m_cnt  = 0;
      end else begin
        m_run = 1;
      end
    end
    @(posedge CLK);
    #1;
    check("D", D, e_d);
    check("DV", DV, e_dv);
    check("DONE", DONE, e_done);
    check("BO", BO, e_bo);
    check("BUSY", BUSY, m_run);
    if (DV && got_dv < 32) got_d[got_dv] = D;
    if (DV) got_dv++;
    if (DONE) got_done++;
  endtask

  task automatic send_word(input logic [7:0] a, input logic [7:0] b, input logic bi,
                           input logic [7:0] stall);
    got_d = '0; got_dv = 0; got_done = 0;
    for (int i = 0; i < int'(W); i++) begin
      step(1'b1, i == 0, a[i], b[i], bi);
      if (stall[i]) begin
        repeat (3) begin
          step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
          check("stall_busy", BUSY, 1);
        end
      end
    end
  endtask

  task automatic check_word(input string name, input logic [7:0] exp_d, input logic exp_bo);
    check({name, "_dstream"}, got_d[7:0], exp_d);
    check({name, "_dvcount"}, got_dv, W);
    check({name, "_donecount"}, got_done, 1);
    check({name, "_bo"}, BO, exp_bo);
  endtask

  initial begin
    int diff1;
    tbl[0] = '{a: 8'h05, b: 8'h03, bi: 1'b0, stall: 8'h00, exp_d: 8'h02, exp_bo: 1'b0};
    tbl[1] = '{a: 8'h03, b: 8'h05, bi: 1'b0, stall: 8'h00, exp_d: 8'hFE, exp_bo: 1'b1};
    tbl[2] = '{a: 8'h10, b: 8'h01, bi: 1'b0, stall: 8'h00, exp_d: 8'h0F, exp_bo: 1'b0};
    tbl[3] = '{a: 8'h00, b: 8'h00, bi: 1'b1, stall: 8'h00, exp_d: 8'hFF, exp_bo: 1'b1};
    tbl[4] = '{a: 8'hA5, b: 8'h5A, bi: 1'b0, stall: 8'h48, exp_d: 8'h4B, exp_bo: 1'b0};

    RN = 1'b0; EN = 0; START = 0; A = 0; B = 0; BI = 0;
    en1 = 0; start1 = 0; a1 = 0; b1 = 0; bi1 = 0;
    got_d = '0; got_dv = 0; got_done = 0;
    model_reset();
    #1;
    check("rst_D", D, 0);
    check("rst_DV", DV, 0);
    check("rst_DONE", DONE, 0);
    check("rst_BO", BO, 0);
    check("rst_BUSY", BUSY, 0);
    check("rst_w1_outs", {d1, dv1, done1, bo1, busy1}, 0);
    repeat (2) @(posedge CLK);
    #3;
    RN = 1'b1;

    // Directed words back to back, the last one with stalls.
    for (int r = 0; r < 5; r++) begin
      send_word(tbl[r].a, tbl[r].b, tbl[r].bi, tbl[r].stall);
      check_word($sformatf("row%0d", r), tbl[r].exp_d, tbl[r].exp_bo);
    end

    // Abort: restart after 4 bits of 0xFF - 0x00.
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    got_done = 0;
    for (int i = 0; i < 4; i++) step(1'b1, i == 0, 1'b1, 1'b0, 1'b0);
    check("abort_partial_done", got_done, 0);
    send_word(8'h00, 8'h01, 1'b0, 8'h00);
    check_word("abort", 8'hFF, 1'b1);

    // Asynchronous reset mid-word.
    got_done = 0;
    for (int i = 0; i < 5; i++) step(1'b1, i == 0, 1'b1, 1'b0, 1'b0);
    #2;
    RN = 1'b0;
    EN = 0;
    #1;
    model_reset();
    check("arst_D", D, 0);
    check("arst_DV", DV, 0);
    check("arst_DONE", DONE, 0);
    check("arst_BO", BO, 0);
    check("arst_BUSY", BUSY, 0);
    check("arst_no_done", got_done, 0);
    repeat (2) @(posedge CLK);
    #3;
    RN = 1'b1;
    send_word(8'h07, 8'h09, 1'b0, 8'h00);
    check_word("after_rst", 8'hFE, 1'b1);
    // EN without START in IDLE is ignored.
    got_dv = 0;
    repeat (3) step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    check("idle_ignore_dv", got_dv, 0);

    // WIDTH=1: every START bit completes a word in one cycle.
    for (int k = 0; k < 8; k++) begin
      en1 = 1; start1 = 1; a1 = k[0]; b1 = k[1]; bi1 = k[2];
      diff1 = int'(a1) - int'(b1) - int'(bi1);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      check("w1_D", d1, diff1[0]);
      check("w1_DV", dv1, 1);
      check("w1_DONE", done1, 1);
      check("w1_BO", bo1, diff1 < 0);
      check("w1_BUSY", busy1, 0);
    end
    en1 = 1; start1 = 1; a1 = 0; b1 = 1; bi1 = 0;
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("w1_spec_D", d1, 1);
    check("w1_spec_BO", bo1, 1);
    en1 = 1; start1 = 0; a1 = 1; b1 = 0;
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("w1_nostart_DV", dv1, 0);
    check("w1_nostart_DONE", done1, 0);
    check("w1_hold_BO", bo1, 1);
    check("w1_idle_BUSY", busy1, 0);
    en1 = 0;

    // Random traffic against the model.
    for (int n = 0; n < 600; n++) begin
      logic en, st;
      en = ($urandom_range(0, 9) < 7);
      st = ($urandom_range(0, 19) == 0) || (!m_run && $urandom_range(0, 2) == 0);
      step(en, st, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
